// File: rtl/cla5_sub_seq_if.sv
// Handshake and operand/result bundle for the sequential limb-serial subtractor.
interface cla5_sub_seq_if #(
  parameter int LIMBS = 4
);
  localparam int W = 5 * LIMBS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         Bout;
  logic         Z;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, D, Bout, Z
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, D, Bout, Z
  );
endinterface

// File: rtl/cla5_sub_seq.sv
// Limb-serial subtractor: one 5-bit carry-lookahead slice computes A + ~B + ~Bin,
// one limb per clock, least significant first, with a valid/ready handshake.
module cla5_sub_seq #(
  parameter int LIMBS = 4
) (
  input logic           clk,
  input logic           rst_n,
  cla5_sub_seq_if.slave bus
);
  localparam int W  = 5 * LIMBS;
  localparam int IW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LIMBS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Returns {carry_out, sum[4:0]}; every carry is a flat generate/propagate term.
  function automatic logic [5:0] cla5(input logic [4:0] a, input logic [4:0] b, input logic c0);
    logic [4:0] g;
    logic [4:0] p;
    logic [5:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2]) | (p[4] & p[3] & p[2] & g[1])
         | (p[4] & p[3] & p[2] & p[1] & g[0]) | (p[4] & p[3] & p[2] & p[1] & p[0] & c0);
    return {c[5], p ^ c[4:0]};
  endfunction

  logic [1:0]    state_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  d_r;
  logic          c_r;
  logic [IW-1:0] idx_r;
  logic          bout_r;
  logic          z_r;
  logic          in_ready_r;
  logic          out_valid_r;

  logic [4:0]    a_limb_s;
  logic [4:0]    b_limb_s;
  logic [5:0]    cla_s;
  logic [W-1:0]  d_next_s;
  logic          last_s;

  // Current limb through the slice; d_next_s is D with that limb written in.
  always_comb begin
    a_limb_s = a_r[32'(idx_r) * 32'd5 +: 5];
    b_limb_s = ~b_r[32'(idx_r) * 32'd5 +: 5];
    cla_s    = cla5(a_limb_s, b_limb_s, c_r);
    d_next_s = d_r;
    d_next_s[32'(idx_r) * 32'd5 +: 5] = cla_s[4:0];
    if (idx_r == LAST_IDX) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Control FSM and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      d_r         <= {W{1'b0}};
      c_r         <= 1'b0;
      idx_r       <= {IW{1'b0}};
      bout_r      <= 1'b0;
      z_r         <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.A;
            b_r        <= bus.B;
            c_r        <= ~bus.Bin;
            idx_r      <= {IW{1'b0}};
            state_r    <= BUSY;
            in_ready_r <= 1'b0;
          end
        end
        BUSY: begin
          d_r   <= d_next_s;
          c_r   <= cla_s[5];
          idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
          if (last_s) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            bout_r      <= ~cla_s[5];
            z_r         <= (d_next_s == {W{1'b0}});
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.D         = d_r;
  assign bus.Bout      = bout_r;
  assign bus.Z         = z_r;
endmodule

// File: tb/tb_cla5_sub_seq.sv
// Directed self-checking bench for cla5_sub_seq with LIMBS = 4 (W = 20).
module tb_cla5_sub_seq;
  localparam int LIMBS = 4;
  localparam int W = 5 * LIMBS;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  cla5_sub_seq_if #(.LIMBS(LIMBS)) bus ();

  cla5_sub_seq #(.LIMBS(LIMBS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand set in IDLE, wait for out_valid, report latency; leaves result in DONE.
  task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                output int lat);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.Bin = bin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.A = 20'h00005;
    bus.B = 20'h00001;
    bus.Bin = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.D !== 20'h00000 || bus.Bout !== 1'b0 || bus.Z !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: D=%h Bout=%b Z=%b, required 00000 0 0", bus.D, bus.Bout, bus.Z);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_accept: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  // One vector: operands, borrow-in, and hand-computed D/Bout/Z.
  task automatic test_vector(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic bin, input logic [W-1:0] exp_d, input logic exp_bout,
                             input logic exp_z);
    int lat;
    start_and_wait(a, b, bin, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges, required 4", name, lat);
    end
    checks++;
    if (bus.D !== exp_d || bus.Bout !== exp_bout || bus.Z !== exp_z || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: D=%h Bout=%b Z=%b in_ready=%b, required D=%h Bout=%b Z=%b in_ready=0",
               name, bus.D, bus.Bout, bus.Z, bus.in_ready, exp_d, exp_bout, exp_z);
    end
    release_result();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.D !== exp_d || bus.Bout !== exp_bout
        || bus.Z !== exp_z) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b D=%h Bout=%b Z=%b, required 0 1 %h %b %b",
               name, bus.out_valid, bus.in_ready, bus.D, bus.Bout, bus.Z, exp_d, exp_bout, exp_z);
    end
  endtask

  task automatic test_arith();
    test_vector("basic",      20'h0000A, 20'h00003, 1'b0, 20'h00007, 1'b0, 1'b0);
    test_vector("wrap",       20'h00000, 20'h00001, 1'b0, 20'hFFFFF, 1'b1, 1'b0);
    test_vector("equal",      20'h12345, 20'h12345, 1'b0, 20'h00000, 1'b0, 1'b1);
    test_vector("equal_bin",  20'h12345, 20'h12345, 1'b1, 20'hFFFFF, 1'b1, 1'b0);
    test_vector("limb_brw",   20'h00020, 20'h00001, 1'b0, 20'h0001F, 1'b0, 1'b0);
    test_vector("max_bin",    20'hFFFFF, 20'h00000, 1'b1, 20'hFFFFE, 1'b0, 1'b0);
    test_vector("top_brw",    20'h80000, 20'h7FFFF, 1'b0, 20'h00001, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    start_and_wait(20'h54321, 20'h11111, 1'b0, lat);
    checks++;
    if (lat !== 4 || bus.D !== 20'h43210 || bus.Bout !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: lat=%0d D=%h Bout=%b, required 4 43210 0", lat, bus.D, bus.Bout);
    end
    // Hold the result under backpressure while in_valid pokes at the busy block.
    bad = 0;
    bus.in_valid = 1'b1;
    bus.A = 20'h00009;
    bus.B = 20'h00002;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.D !== 20'h43210 || bus.Bout !== 1'b0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0 (last D=%h out_valid=%b)",
               bad, bus.D, bus.out_valid);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.D !== 20'h43210) begin
      errors++;
      $display("FAIL b2b_idle: out_valid=%b in_ready=%b D=%h, required 0 1 43210",
               bus.out_valid, bus.in_ready, bus.D);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: in_ready=%b, required 0", bus.in_ready);
    end
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 4 || bus.D !== 20'h00007 || bus.Bout !== 1'b0 || bus.Z !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: lat=%0d D=%h Bout=%b Z=%b, required 4 00007 0 0",
               lat, bus.D, bus.Bout, bus.Z);
    end
    release_result();
  endtask

  task automatic test_mid_busy_reset();
    int seen;
    int lat;
    @(negedge clk);
    bus.A = 20'h00400;
    bus.B = 20'h00001;
    bus.Bin = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.D !== 20'h00000) begin
      errors++;
      $display("FAIL midrst: in_ready=%b out_valid=%b D=%h, required 1 0 00000",
               bus.in_ready, bus.out_valid, bus.D);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrst_quiet: %0d cycles with activity, required 0", seen);
    end
    start_and_wait(20'h00400, 20'h00001, 1'b0, lat);
    checks++;
    if (lat !== 4 || bus.D !== 20'h003FF || bus.Bout !== 1'b0 || bus.Z !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: lat=%0d D=%h Bout=%b Z=%b, required 4 003FF 0 0",
               lat, bus.D, bus.Bout, bus.Z);
    end
    release_result();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Bin = 1'b0;
    test_reset();
    test_arith();
    test_back_to_back();
    test_mid_busy_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cla5_sub_seq.md
CLA5_SUB_SEQ -- requirements
Module: cla5_sub_seq

Interface
REQ-001 Parameter: LIMBS, 4, number of 5-bit limbs per operand (operand width W = 5*LIMBS, LIMBS >= 1).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 A  input  W  minuend.
REQ-007 B  input  W  subtrahend.
REQ-008 Bin  input  1  borrow-in.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 D  output  W  difference, A - B - Bin mod 2^W.
REQ-012 Bout  output  1  borrow-out; 1 when A < B + Bin, unsigned.
REQ-013 Z  output  1  D equals zero.

Function
REQ-014 Arithmetic: one 5-bit carry-lookahead slice shall compute limb i as A[i] + ~B[i] + c, with generate/propagate carries and no ripple inside the slice.
REQ-015 Carry c shall initialise to ~Bin at accept and shall chain slice carry-out to the next limb.
REQ-016 Bout shall equal the inverse of the final limb carry-out.
REQ-017 FSM states: IDLE, BUSY, DONE.
REQ-018 IDLE: in_ready = 1, out_valid = 0.
REQ-019 Accept occurs on an edge where in_valid & in_ready; the block shall latch A, B and ~Bin, set limb index to 0 and enter BUSY.
REQ-020 BUSY: in_ready = 0, out_valid = 0; inputs other than rst_n are ignored.
REQ-021 BUSY: each edge shall process exactly one limb, least significant first, write it into D[5i+4:5i], update c and increment the index.
REQ-022 BUSY: on the edge that processes limb LIMBS-1, the FSM shall enter DONE and register Bout and Z.
REQ-023 Latency: out_valid shall rise exactly LIMBS edges after the accepting edge (LIMBS=4 gives 4 cycles).
REQ-024 DONE: out_valid = 1, in_ready = 0; D, Bout and Z shall stay stable until the handshake.
REQ-025 DONE with out_ready = 1 on an edge: the FSM shall return to IDLE; D, Bout and Z keep their values, and out_valid drops.
REQ-026 DONE with out_ready = 0: the FSM shall stay in DONE indefinitely (backpressure).
REQ-027 No overlap: a new accept shall occur no earlier than the edge after the return to IDLE; throughput is 1 result per LIMBS+2 cycles maximum.
REQ-028 in_valid asserted outside IDLE shall have no effect.
REQ-029 Z shall be computed over all W result bits and shall not depend on Bout.
REQ-030 LIMBS = 1: BUSY shall last one edge and behave as a single registered 5-bit subtract.

Reset
REQ-031 When rst_n = 0 on an edge, the block shall enter IDLE, clear D, Bout, Z, c and the index, and set out_valid = 0 and in_ready = 1 from the following cycle.
REQ-032 Reset shall take priority over every other event, including mid-BUSY and a simultaneous accept; the partial result shall be discarded.
REQ-033 in_valid held high while rst_n = 0 shall not cause an accept on that edge.

Verification (LIMBS = 4, W = 20)
REQ-034 A=0x0000A, B=0x00003, Bin=0 -> D=0x00007, Bout=0, Z=0; out_valid rises 4 edges after accept.
REQ-035 A=0x00000, B=0x00001, Bin=0 -> D=0xFFFFF, Bout=1, Z=0 (borrow crosses all limbs).
REQ-036 A=0x12345, B=0x12345, Bin=0 -> D=0x00000, Bout=0, Z=1; same operands with Bin=1 -> D=0xFFFFF, Bout=1, Z=0.
REQ-037 A=0x00020, B=0x00001, Bin=0 -> D=0x0001F, Bout=0 (limb-boundary borrow).
REQ-038 out_ready held 0 for 10 cycles in DONE -> out_valid, D and Bout stay stable and in_ready=0; out_ready=1 -> IDLE on the next edge, and a back-to-back in_valid is accepted one edge later.
REQ-039 rst_n=0 on the 2nd BUSY edge -> IDLE, D=0, out_valid never asserted; a new operation after reset completes correctly.
